lane_serializer: RTL and testbench
==================================

Name: lane_serializer

Overview:
- Multi-lane, runtime-configurable parallel-to-serial converter; next generation of the single-lane frame serializer in the FEC TX path.
- Accepts one frame of LANES x DATA_DEPTH words via valid/ready handshake.
- Shifts each lane's words out on its own serial line, sharing one bit strobe; selectable bit order and bit-rate divider.
- Sits between the encoder output buffer and the line/PHY interface.

Parameters:
- DATA_WIDTH, 32, maximum bits per word.
- DATA_DEPTH, 4, maximum words per lane per frame.
- LANES, 2, number of parallel serial lanes (>=1).
- DIV_WIDTH, 8, width of the bit-period divider.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  frame present on par_in.
- in_ready  out  1  block can accept a frame.
- par_in  in  LANES*DATA_DEPTH*DATA_WIDTH  packed [LANES][DATA_DEPTH][DATA_WIDTH]; lane l sends par_in[l][0..] in order.
- width_m1  in  $clog2(DATA_WIDTH)  bits per word minus 1; sampled at accept.
- depth_m1  in  $clog2(DATA_DEPTH)  words per lane minus 1; sampled at accept.
- clk_div  in  DIV_WIDTH  each bit is held clk_div+1 cycles; sampled at accept.
- msb_first  in  1  1: bit width_m1 first; 0: bit 0 first; sampled at accept.
- abort  in  1  terminate current frame.
- serial_out  out  LANES  serial data, one bit per lane.
- serial_en  out  1  serial_out valid.
- bit_strobe  out  1  one-cycle pulse on the first cycle of each bit period.
- done  out  1  one-cycle pulse after a complete frame.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE; serial_out=0, serial_en=0, bit_strobe=0, done=0, busy=0, all counters 0. in_ready=1 after reset deasserts.
- rst mid-frame: abandons the frame with no done pulse. rst wins over every other input.
- in_ready: combinational, 1 only in IDLE. Accept = in_valid & in_ready at a posedge; captures par_in and all config inputs.
- States: IDLE -> TX on accept. TX -> DONE after the last bit period. DONE -> IDLE after one cycle.
- TX -> IDLE on abort at the next edge. abort is ignored in IDLE and DONE.
- Latency:
  - serial_en=1, bit_strobe=1 and the first bit appear on the cycle following the accept edge.
  - Every bit is held exactly clk_div+1 cycles; clk_div=0 gives one bit per cycle.
- Order per lane: word 0..depth_m1; within a word, bits per msb_first. All lanes are bit-aligned.
- Counters:
  - div_cnt counts 0..clk_div.
  - bit_cnt counts 0..width_m1.
  - word_cnt counts 0..depth_m1.
  - Wrap when div_cnt==clk_div, cascading.
  - Unsigned compares, no overflow: counters are sized to hold the maximums.
- Frame end:
  - The edge ending the final period sets serial_en=0, serial_out=0, done=1 (DONE state).
  - done=0 and in_ready=1 the following cycle.
  - serial_en high time = (clk_div+1)*(width_m1+1)*(depth_m1+1) cycles; 1 more bit per word if parity is enabled.
- Abort: serial_en=0 and serial_out=0 at the next edge, no done, in_ready=1 the cycle after.
- Back-to-back: minimum gap between frames is 2 cycles (DONE + IDLE accept).
- Config changes outside accept have no effect.
- width_m1 > DATA_WIDTH-1 or depth_m1 > DATA_DEPTH-1: saturated to the maximum at capture.

Optional Feature:
- Macro LANE_SERIALIZER_PARITY_EN.
- Defined:
  - Adds input parity_odd.
  - After each word's last data bit, each lane sends one parity bit over that word's bits: even parity (XOR) when parity_odd=0, inverted when parity_odd=1.
  - The parity bit has the same clk_div+1 hold and its own bit_strobe.
- Undefined: no parity port, no parity bit, words are back-to-back.

Decomposition:
- Package lane_ser_pkg:
  - state_t enum {IDLE, TX, DONE}.
  - Width helper localparams: counter widths via $clog2.
  - Saturation function for width/depth.
- Sub-module ser_bit_timer: div_cnt, bit_strobe and period-end flag from clk_div. Reusable by the future deserializer.
- Lane data selection stays in the top-level generate loop.

Test Plan:
- LANES=2, width_m1=7, depth_m1=1, clk_div=0, msb_first=0, lane0={0xA5,0x3C}, lane1={0xFF,0x00}:
  - lane0 emits 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0; lane1 emits eight 1s then eight 0s.
  - serial_en high 16 cycles; done pulses 1 cycle later.
- Same frame, clk_div=3, msb_first=1: each bit held 4 cycles, lane0 first bits 1,0,1,0; bit_strobe every 4th cycle; serial_en high 64 cycles.
- abort asserted on cycle 5 of TX: serial_en=0 next cycle, no done, in_ready=1 the cycle after; a new frame is accepted and sent correctly.
- in_valid held high with two frames: the second is accepted exactly 2 cycles after the first done; in_ready=0 throughout TX.
- rst=1 mid-frame with clk_div=2: all outputs 0 at the next edge, no done; then width_m1=31, depth_m1=3, clk_div=0 gives a full 128-cycle frame.
- LANE_SERIALIZER_PARITY_EN, width_m1=7, 0xA5, parity_odd=0: the 9th bit is 0. With parity_odd=1 it is 1. serial_en high 9*(depth_m1+1) cycles.

Source files
------------

// File: rtl/lane_ser_pkg.sv
// rtl/lane_ser_pkg.sv - shared types and helpers for the lane serializer family
// Purpose: FSM state type, counter width helper, config saturation and the
// parity bit count selected by LANE_SERIALIZER_PARITY_EN.
package lane_ser_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TX   = 2'd1,
        DONE = 2'd2
    } state_t;

    // Extra bit periods appended to every word (the parity bit).
`ifdef LANE_SERIALIZER_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Bits needed to index n items; never below 1 so degenerate sizes still elaborate.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Clamp a requested minus-one config value to the largest one the buffer holds.
    function automatic int unsigned sat_cfg(input int unsigned v, input int unsigned max_v);
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/ser_bit_timer.sv
// rtl/ser_bit_timer.sv - bit-period timer shared by serializer and deserializer
// Purpose: divides clk into bit periods of clk_div+1 cycles while run is high.
// Ports: clk, rst (sync, active-high), run (timer enabled), clear (restart the
// period), clk_div (period minus 1), bit_strobe (first cycle of a period),
// period_end (last cycle of a period).
module ser_bit_timer #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 clear,
    input  logic [DIV_WIDTH-1:0] clk_div,
    output logic                 bit_strobe,
    output logic                 period_end
);

    logic [DIV_WIDTH-1:0] div_cnt;

    // The counter rests at 0 whenever the timer is stopped, so the first cycle
    // after run rises is always a strobe cycle.
    always_ff @(posedge clk) begin
        if (rst || clear || !run) begin
            div_cnt <= '0;
        end else if (period_end) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_WIDTH'(1);
        end
    end

    assign bit_strobe = run && (div_cnt == '0);
    assign period_end = run && (div_cnt == clk_div);

endmodule

// File: rtl/lane_serializer.sv
// rtl/lane_serializer.sv - multi-lane frame parallel-to-serial converter
// Purpose: accepts one LANES x DATA_DEPTH word frame and shifts each lane out
// on its own serial line with a shared bit strobe. Optional per-word parity bit
// with LANE_SERIALIZER_PARITY_EN (adds input parity_odd).
// Ports: clk, rst (sync, active-high); in_valid/in_ready frame handshake;
// par_in frame data; width_m1, depth_m1, clk_div, msb_first config captured at
// accept; abort ends the frame; serial_out per-lane data, serial_en,
// bit_strobe, done pulse, busy.
module lane_serializer
    import lane_ser_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_DEPTH = 4,
    parameter int LANES      = 2,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            in_valid,
    output logic                                            in_ready,
    input  logic [LANES-1:0][DATA_DEPTH-1:0][DATA_WIDTH-1:0] par_in,
    input  logic [cnt_w(DATA_WIDTH)-1:0]                    width_m1,
    input  logic [cnt_w(DATA_DEPTH)-1:0]                    depth_m1,
    input  logic [DIV_WIDTH-1:0]                            clk_div,
    input  logic                                            msb_first,
`ifdef LANE_SERIALIZER_PARITY_EN
    input  logic                                            parity_odd,
`endif
    input  logic                                            abort,
    output logic [LANES-1:0]                                serial_out,
    output logic                                            serial_en,
    output logic                                            bit_strobe,
    output logic                                            done,
    output logic                                            busy
);

    localparam int WW = cnt_w(DATA_WIDTH);
    localparam int DW = cnt_w(DATA_DEPTH);
    // One extra bit so the counter can also reach the parity position.
    localparam int BW = WW + 1;

    state_t state, state_n;

    logic [LANES-1:0][DATA_DEPTH-1:0][DATA_WIDTH-1:0] data_r;
    logic [WW-1:0]        width_r;
    logic [DW-1:0]        depth_r;
    logic [DIV_WIDTH-1:0] div_r;
    logic                 msb_r;
`ifdef LANE_SERIALIZER_PARITY_EN
    logic                 parity_odd_r;
`endif

    logic [BW-1:0] bit_cnt;
    logic [BW-1:0] bit_last;
    logic [DW-1:0] word_cnt;
    logic          tx;
    logic          accept;
    logic          period_end;
    logic          word_end;
    logic          last_period;

    assign tx          = (state == TX);
    assign in_ready    = (state == IDLE);
    assign accept      = in_valid && in_ready;
    assign bit_last    = BW'(width_r) + BW'(PARITY_BITS);
    assign word_end    = (bit_cnt == bit_last);
    assign last_period = period_end && word_end && (word_cnt == depth_r);

    ser_bit_timer #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .run        (tx),
        .clear      (abort),
        .clk_div    (div_r),
        .bit_strobe (bit_strobe),
        .period_end (period_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = TX;
            TX: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (last_period) begin
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Frame and config capture; nothing here moves outside the accept edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r       <= '0;
            width_r      <= '0;
            depth_r      <= '0;
            div_r        <= '0;
            msb_r        <= 1'b0;
`ifdef LANE_SERIALIZER_PARITY_EN
            parity_odd_r <= 1'b0;
`endif
        end else if (accept) begin
            data_r       <= par_in;
            width_r      <= WW'(sat_cfg(32'(width_m1), DATA_WIDTH - 1));
            depth_r      <= DW'(sat_cfg(32'(depth_m1), DATA_DEPTH - 1));
            div_r        <= clk_div;
            msb_r        <= msb_first;
`ifdef LANE_SERIALIZER_PARITY_EN
            parity_odd_r <= parity_odd;
`endif
        end
    end

    // Bit and word position, advanced at the end of each bit period.
    always_ff @(posedge clk) begin
        if (rst || !tx || abort) begin
            bit_cnt  <= '0;
            word_cnt <= '0;
        end else if (period_end) begin
            if (word_end) begin
                bit_cnt  <= '0;
                word_cnt <= (word_cnt == depth_r) ? '0 : word_cnt + DW'(1);
            end else begin
                bit_cnt  <= bit_cnt + BW'(1);
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [DATA_WIDTH-1:0] word;
        logic [WW-1:0]         idx;
        logic                  data_bit;

        assign word     = data_r[l][word_cnt];
        assign idx      = msb_r ? (width_r - bit_cnt[WW-1:0]) : bit_cnt[WW-1:0];
        assign data_bit = word[idx];

`ifdef LANE_SERIALIZER_PARITY_EN
        logic [DATA_WIDTH-1:0] mask;
        logic                  par_bit;

        // Keep only the bits actually sent for this word.
        assign mask    = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - 1 - int'(width_r));
        assign par_bit = (^(word & mask)) ^ parity_odd_r;
        assign serial_out[l] = tx && ((bit_cnt > BW'(width_r)) ? par_bit : data_bit);
`else
        assign serial_out[l] = tx && data_bit;
`endif
    end

    assign serial_en = tx;
    assign done      = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_lane_serializer.sv
// tb/tb_lane_serializer.sv - directed self-checking bench for lane_serializer
module tb_lane_serializer;

    localparam int DWID = 32;
    localparam int DDEP = 4;
    localparam int NL   = 2;

    logic                                 clk = 1'b0;
    logic                                 rst = 1'b1;
    logic                                 in_valid = 1'b0;
    logic                                 in_ready;
    logic [NL-1:0][DDEP-1:0][DWID-1:0]    par_in = '0;
    logic [4:0]                           width_m1 = '0;
    logic [1:0]                           depth_m1 = '0;
    logic [7:0]                           clk_div = '0;
    logic                                 msb_first = 1'b0;
`ifdef LANE_SERIALIZER_PARITY_EN
    logic                                 parity_odd = 1'b0;
`endif
    logic                                 abort = 1'b0;
    logic [NL-1:0]                        serial_out;
    logic                                 serial_en;
    logic                                 bit_strobe;
    logic                                 done;
    logic                                 busy;

    lane_serializer #(
        .DATA_WIDTH (DWID),
        .DATA_DEPTH (DDEP),
        .LANES      (NL),
        .DIV_WIDTH  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .par_in     (par_in),
        .width_m1   (width_m1),
        .depth_m1   (depth_m1),
        .clk_div    (clk_div),
        .msb_first  (msb_first),
`ifdef LANE_SERIALIZER_PARITY_EN
        .parity_odd (parity_odd),
`endif
        .abort      (abort),
        .serial_out (serial_out),
        .serial_en  (serial_en),
        .bit_strobe (bit_strobe),
        .done       (done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [127:0] cap0, cap1;
    int           nbits, en_cnt, str_cnt, hold_err;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_lane(input int l, input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3);
        par_in[l][0] = w0;
        par_in[l][1] = w1;
        par_in[l][2] = w2;
        par_in[l][3] = w3;
    endtask

    // Accept one frame, then scramble the config inputs, which must not matter.
    task automatic start(input logic [4:0] w, input logic [1:0] d, input logic [7:0] dv,
                         input logic msb);
        width_m1  = w;
        depth_m1  = d;
        clk_div   = dv;
        msb_first = msb;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        width_m1  = 5'd1;
        depth_m1  = 2'd0;
        clk_div   = 8'd5;
        msb_first = ~msb;
    endtask

    // Record one bit per strobe while serial_en is high, then check the frame end.
    task automatic capture(input string tag);
        logic [NL-1:0] prev;
        prev     = 'x;
        cap0     = '0;
        cap1     = '0;
        nbits    = 0;
        en_cnt   = 0;
        str_cnt  = 0;
        hold_err = 0;
        for (int c = 0; c < 2000 && serial_en; c++) begin
            if (bit_strobe) begin
                if (nbits < 128) begin
                    cap0[nbits] = serial_out[0];
                    cap1[nbits] = serial_out[1];
                end
                nbits++;
                str_cnt++;
                prev = serial_out;
            end else if (serial_out !== prev) begin
                hold_err++;
            end
            en_cnt++;
            tick();
        end
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_out0"}, serial_out, 2'b00);
        tick();
        check({tag, "_done_clr"}, done, 1'b0);
        check({tag, "_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        int done_c, s2, rdy_bad;
        logic prev_en;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_en", serial_en, 1'b0);
        check("rst_out", serial_out, 2'b00);
        check("rst_strobe", bit_strobe, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        tick();
        check("rst_ready", in_ready, 1'b1);

        // Basic LSB-first frame, one bit per cycle
        load_lane(0, 32'hA5, 32'h3C, 32'h0, 32'h0);
        load_lane(1, 32'hFF, 32'h00, 32'h0, 32'h0);
        start(5'd7, 2'd1, 8'd0, 1'b0);
        check("t1_first_en", serial_en, 1'b1);
        check("t1_first_strobe", bit_strobe, 1'b1);
        check("t1_first_ready", in_ready, 1'b0);
        check("t1_first_busy", busy, 1'b1);
        capture("t1");
        check("t1_en", en_cnt, 16);
        check("t1_lane0", cap0, 128'h3CA5);
        check("t1_lane1", cap1, 128'h00FF);
        check("t1_hold", hold_err, 0);

        // Divided clock, MSB first
        start(5'd7, 2'd1, 8'd3, 1'b1);
        capture("t2");
        check("t2_en", en_cnt, 64);
        check("t2_strobes", str_cnt, 16);
        check("t2_lane0", cap0, 128'h3CA5);
        check("t2_lane1", cap1, 128'h00FF);
        check("t2_hold", hold_err, 0);

        // Asymmetric data, MSB first
        load_lane(0, 32'h12, 32'h34, 32'h0, 32'h0);
        load_lane(1, 32'hF0, 32'h0F, 32'h0, 32'h0);
        start(5'd7, 2'd1, 8'd0, 1'b1);
        capture("t3");
        check("t3_en", en_cnt, 16);
        check("t3_lane0", cap0, 128'h2C48);
        check("t3_lane1", cap1, 128'hF00F);

        // Narrow words (4 bits), 3 words, clk_div=1
        load_lane(0, 32'hF5, 32'hA9, 32'h73, 32'hFFFF_FFFF);
        load_lane(1, 32'h0E, 32'h01, 32'h08, 32'hFFFF_FFFF);
        start(5'd3, 2'd2, 8'd1, 1'b0);
        capture("t4");
        check("t4_en", en_cnt, 24);
        check("t4_strobes", str_cnt, 12);
        check("t4_lane0", cap0, 128'h395);
        check("t4_lane1", cap1, 128'h81E);
        check("t4_hold", hold_err, 0);

        // Abort on the 5th TX cycle, then a clean frame
        load_lane(0, 32'hA5, 32'h3C, 32'h0, 32'h0);
        load_lane(1, 32'hFF, 32'h00, 32'h0, 32'h0);
        start(5'd7, 2'd1, 8'd0, 1'b0);
        tick();
        tick();
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_en", serial_en, 1'b0);
        check("ab_out", serial_out, 2'b00);
        check("ab_done", done, 1'b0);
        check("ab_ready", in_ready, 1'b1);
        tick();
        check("ab_done2", done, 1'b0);
        load_lane(0, 32'h12, 32'h34, 32'h0, 32'h0);
        load_lane(1, 32'hF0, 32'h0F, 32'h0, 32'h0);
        start(5'd7, 2'd1, 8'd0, 1'b1);
        capture("ab_next");
        check("ab_next_lane0", cap0, 128'h2C48);
        check("ab_next_lane1", cap1, 128'hF00F);

        // Back-to-back with in_valid held high
        width_m1  = 5'd3;
        depth_m1  = 2'd0;
        clk_div   = 8'd0;
        msb_first = 1'b0;
        in_valid  = 1'b1;
        tick();
        done_c  = -1;
        s2      = -1;
        rdy_bad = 0;
        prev_en = 1'b1;
        for (int c = 0; c < 200 && s2 < 0; c++) begin
            if (done && done_c < 0) done_c = c;
            if (serial_en && !prev_en) s2 = c;
            if (serial_en && in_ready) rdy_bad++;
            prev_en = serial_en;
            tick();
        end
        in_valid = 1'b0;
        check("b2b_found", (s2 >= 0 && done_c >= 0), 1'b1);
        check("b2b_gap", 128'(s2 - done_c), 128'd2);
        check("b2b_ready_tx", rdy_bad, 0);
        capture("b2b");

        // Reset mid-frame, then a full-size frame
        load_lane(0, 32'hA5, 32'h3C, 32'h0, 32'h0);
        load_lane(1, 32'hFF, 32'h00, 32'h0, 32'h0);
        start(5'd7, 2'd1, 8'd2, 1'b0);
        tick();
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rm_en", serial_en, 1'b0);
        check("rm_out", serial_out, 2'b00);
        check("rm_strobe", bit_strobe, 1'b0);
        check("rm_done", done, 1'b0);
        check("rm_busy", busy, 1'b0);
        rst = 1'b0;
        tick();
        check("rm_ready", in_ready, 1'b1);
        check("rm_done2", done, 1'b0);
        load_lane(0, 32'h0123_4567, 32'h89AB_CDEF, 32'hDEAD_BEEF, 32'h0BAD_F00D);
        load_lane(1, 32'hFEDC_BA98, 32'h7654_3210, 32'h2152_4110, 32'hF452_0FF2);
        start(5'd31, 2'd3, 8'd0, 1'b0);
        capture("full");
        check("full_en", en_cnt, 128);
        check("full_lane0", cap0, 128'h0BADF00D_DEADBEEF_89ABCDEF_01234567);
        check("full_lane1", cap1, 128'hF4520FF2_21524110_76543210_FEDCBA98);

`ifdef LANE_SERIALIZER_PARITY_EN
        load_lane(0, 32'hA5, 32'hA5, 32'h0, 32'h0);
        load_lane(1, 32'hFF, 32'h00, 32'h0, 32'h0);
        parity_odd = 1'b0;
        start(5'd7, 2'd1, 8'd0, 1'b0);
        capture("par_even");
        check("par_even_en", en_cnt, 18);
        check("par_even_lane0", cap0, 128'hA5 | (128'hA5 << 9));
        check("par_even_lane1", cap1, 128'hFF);
        parity_odd = 1'b1;
        start(5'd7, 2'd1, 8'd0, 1'b0);
        capture("par_odd");
        check("par_odd_en", en_cnt, 18);
        check("par_odd_lane0", cap0, 128'hA5 | (128'h1 << 8) | (128'hA5 << 9) | (128'h1 << 17));
        check("par_odd_lane1", cap1, 128'hFF | (128'h1 << 8) | (128'h1 << 17));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
